// File: rtl/core_pkg.sv
// Shared core definitions: register-file defaults, the zero register index and
// helpers for locating a port's field inside a packed multi-port bus.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  // Lowest bit of port `port` in a bus of fields that are `width` bits each.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

  // Total width of a packed bus carrying `ports` fields of `width` bits.
  function automatic int bus_width(input int ports, input int width);
    return ports * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers awaiting write-back, guards WAW
// reservations and flags RAW hazards on every read port.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic                 iss_ready,
  output logic [NUM_RD-1:0]    rd_hazard,
  output logic [AW:0]          pending_cnt
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [NREG-1:0] busy_r;
  logic [AW:0]     cnt_r;
  logic [NREG-1:0] set_vec_s;
  logic [NREG-1:0] clr_vec_s;
  logic            ready_s;
  logic            set_s;
  logic            clr_s;
  logic            inc_s;
  logic            dec_s;
  logic [NUM_RD-1:0] haz_s;

  // WAW guard, set/clear decode and counter step conditions
  always_comb begin
    ready_s   = (iss_addr == ZERO_A) | ~busy_r[iss_addr] |
                (wb_en & (wb_addr == iss_addr));
    set_s     = iss_en & ready_s & (iss_addr != ZERO_A);
    clr_s     = wb_en & (wb_addr != ZERO_A);
    set_vec_s = '0;
    clr_vec_s = '0;
    if (set_s) begin
      set_vec_s = NREG'(1) << iss_addr;
    end else begin
      set_vec_s = '0;
    end
    if (clr_s) begin
      clr_vec_s = NREG'(1) << wb_addr;
    end else begin
      clr_vec_s = '0;
    end
    // A clear cancelled by a re-set of the same register leaves the count alone.
    inc_s = set_s & ~busy_r[iss_addr];
    dec_s = clr_s & busy_r[wb_addr] & ~(set_s & (iss_addr == wb_addr));
  end

  // RAW hazard per read port; a same-cycle write-back resolves it via bypass
  always_comb begin
    haz_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      haz_s[i] = busy_r[rd_addr[port_lsb(i, AW) +: AW]] &
                 ~(wb_en & (wb_addr == rd_addr[port_lsb(i, AW) +: AW]));
    end
  end

  // Busy vector: set wins over clear on the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_vec_s) | set_vec_s;
    end
  end

  // Up/down count of busy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (inc_s & ~dec_s) begin
      cnt_r <= cnt_r + (AW+1)'(1);
    end else if (dec_s & ~inc_s) begin
      cnt_r <= cnt_r - (AW+1)'(1);
    end
  end

  assign iss_ready   = ready_s;
  assign rd_hazard   = haz_s;
  assign pending_cnt = cnt_r;

endmodule

// File: rtl/reg_scoreboard_chk.sv
// Checker: the busy counter can never exceed the number of non-zero registers.
module reg_scoreboard_chk #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input logic        clk,
  input logic        rst,
  input logic [AW:0] pending_cnt
);

  localparam logic [AW:0] MAX_CNT = (AW+1)'(NREG - 1);

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    pending_cnt <= MAX_CNT);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-first bypass, busy scoreboard and a
// registered debug read port.
module reg_file_sb
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NUM_RD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_hazard,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic                   iss_ready,
  output logic [AW:0]            pending_cnt,
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_data
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [XLEN-1:0]                     regs_r [NREG];
  logic [XLEN-1:0]                     dbg_data_r;
  logic [bus_width(NUM_RD, XLEN)-1:0]  rd_data_s;
  logic [AW-1:0]                       rd_idx_s [NUM_RD];
  logic                                wr_s;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_idx
    assign rd_idx_s[g] = rd_addr[port_lsb(g, AW) +: AW];
  end

  assign wr_s = wb_en & (wb_addr != ZERO_A);

  // Read muxes; x0 is never written so the array entry stays zero
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (wr_s && (wb_addr == rd_idx_s[i])) begin
        rd_data_s[port_lsb(i, XLEN) +: XLEN] = wb_data;
      end else begin
        rd_data_s[port_lsb(i, XLEN) +: XLEN] = regs_r[rd_idx_s[i]];
      end
    end
  end

  // Data array write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_s) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Debug capture samples the array before this edge's write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_data_r <= '0;
    end else begin
      dbg_data_r <= regs_r[dbg_addr];
    end
  end

  reg_scoreboard #(
    .NREG   (NREG),
    .NUM_RD (NUM_RD),
    .AW     (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .rd_addr     (rd_addr),
    .iss_ready   (iss_ready),
    .rd_hazard   (rd_hazard),
    .pending_cnt (pending_cnt)
  );

  reg_scoreboard_chk #(
    .NREG (NREG),
    .AW   (AW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .pending_cnt (pending_cnt)
  );

  assign rd_data  = rd_data_s;
  assign dbg_data = dbg_data_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb (NREG=16, NUM_RD=3): directed scenarios then
// random traffic, all checked against an array-based reference model.
module tb_reg_file_sb;

  localparam int XLEN   = 32;
  localparam int NREG   = 16;
  localparam int AW     = 4;
  localparam int NUM_RD = 3;

  typedef struct {
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      hazard;
    logic                   ready;
    logic [AW:0]            pend;
    logic [XLEN-1:0]        dbg;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_hazard;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   iss_ready;
  logic [AW:0]            pending_cnt;
  logic [AW-1:0]          dbg_addr;
  logic [XLEN-1:0]        dbg_data;

  logic [XLEN-1:0] regs_m [NREG];
  bit              busy_m [NREG];
  logic [XLEN-1:0] dbg_m;
  exp_t            exp_q [$];
  int              total = 0;
  int              bad   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_hazard(rd_hazard), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .pending_cnt(pending_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      regs_m[i] = '0;
      busy_m[i] = 1'b0;
    end
    dbg_m = '0;
  endtask

  // One cycle: drive at the falling edge, predict, then retire at the rising edge.
  task automatic step(input logic [NUM_RD*AW-1:0] ra, input logic we, input logic [AW-1:0] wa,
                      input logic [XLEN-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                      input logic [AW-1:0] da, input logic r);
    exp_t e;
    int   n;
    logic accept;
    @(negedge clk);
    rd_addr = ra; wb_en = we; wb_addr = wa; wb_data = wd;
    iss_en = ie; iss_addr = ia; dbg_addr = da; rst = r;
    if (r) model_reset();
    e.rd_data = '0;
    e.hazard  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      int a;
      a = int'(ra[i*AW +: AW]);
      if (a == 0)                          e.rd_data[i*XLEN +: XLEN] = '0;
      else if (we && int'(wa) == a)        e.rd_data[i*XLEN +: XLEN] = wd;
      else                                 e.rd_data[i*XLEN +: XLEN] = regs_m[a];
      e.hazard[i] = (a != 0) && busy_m[a] && !(we && int'(wa) == a);
    end
    e.ready = (ia == 0) || !busy_m[ia] || (we && wa == ia);
    n = 0;
    for (int i = 0; i < NREG; i++) n += int'(busy_m[i]);
    e.pend = (AW+1)'(n);
    e.dbg  = dbg_m;
    exp_q.push_back(e);
    accept = ie && e.ready && (ia != 0);
    @(posedge clk);
    #1;
    if (!r) begin
      dbg_m = regs_m[da];
      if (we && wa != 0) begin
        regs_m[wa] = wd;
        busy_m[wa] = 1'b0;
      end
      if (accept) busy_m[ia] = 1'b1;
    end
  endtask

  function automatic logic [NUM_RD*AW-1:0] ra1(input int a);
    return (NUM_RD*AW)'(a);
  endfunction

  // Monitor: every cycle, before the rising edge, compare DUT against predictions
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data", 128'(rd_data), 128'(e.rd_data));
        check("rd_hazard", 128'(rd_hazard), 128'(e.hazard));
        check("iss_ready", 128'(iss_ready), 128'(e.ready));
        check("pending_cnt", 128'(pending_cnt), 128'(e.pend));
        check("dbg_data", 128'(dbg_data), 128'(e.dbg));
        total++;
        if (pending_cnt > (AW+1)'(NREG - 1)) begin
          bad++;
          $display("FAIL pending_cnt_max: got %0d limit %0d", pending_cnt, NREG - 1);
        end
      end
    end
  end

  initial begin
    int blist [$];
    logic [NUM_RD*AW-1:0] ra;
    logic we, ie, r;
    logic [AW-1:0] wa, ia;
    rst = 1'b1; rd_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0; dbg_addr = '0;
    model_reset();

    step('0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b1);
    // x0 writes and reservations have no effect
    step(ra1(0), 1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd0, 4'd0, 1'b0);
    step(ra1(0), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0);
    // bypass then array read of x7
    step(ra1(7), 1'b1, 4'd7, 32'hCAFEF00D, 1'b0, 4'd0, 4'd7, 1'b0);
    step(ra1(7), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 1'b0);
    // hazard flow on x3
    step(ra1(3), 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd0, 1'b0);
    step(ra1(3), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0);
    step(ra1(3), 1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 4'd3, 1'b0);
    step(ra1(3), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 1'b0);
    // WAW guard on x4
    step(ra1(4), 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd0, 1'b0);
    step(ra1(4), 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd0, 1'b0);
    step(ra1(4), 1'b1, 4'd4, 32'h44, 1'b1, 4'd4, 4'd0, 1'b0);
    step(ra1(4), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 1'b0);
    step(ra1(4), 1'b1, 4'd4, 32'h45, 1'b0, 4'd0, 4'd4, 1'b0);
    // reset mid-run with x5 holding data and busy
    step(ra1(5), 1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 4'd0, 1'b0);
    step(ra1(5), 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd5, 1'b0);
    step(ra1(5), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 1'b0);
    step(ra1(5), 1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 4'd5, 1'b1);
    step(ra1(5), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 1'b0);

    for (int c = 0; c < 10000; c++) begin
      blist.delete();
      for (int i = 1; i < NREG; i++) if (busy_m[i]) blist.push_back(i);
      for (int i = 0; i < NUM_RD; i++) ra[i*AW +: AW] = AW'($urandom_range(0, NREG - 1));
      r  = ($urandom_range(0, 499) == 0);
      we = !r && ($urandom_range(0, 1) == 1);
      if (blist.size() > 0 && $urandom_range(0, 9) < 7)
        wa = AW'(blist[$urandom_range(0, blist.size() - 1)]);
      else
        wa = AW'($urandom_range(0, NREG - 1));
      ie = ($urandom_range(0, 1) == 1);
      ia = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1));
      step(ra, we, wa, $urandom, ie, ia, AW'($urandom_range(0, NREG - 1)), r);
    end

    @(negedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
